// File: rtl/config_chain_pkg.sv
// config_chain_pkg: shared types and defaults for the configuration chain loader.
//   state_t       : loader FSM state encoding (CHECK only reachable with CONFIG_PARITY_EN)
//   STATE_W       : width of the state encoding
//   DEF_WORD_W    : default bitstream word width
//   DEF_CHAIN_LEN : default number of ccff cells in the chain
package config_chain_pkg;

    localparam int unsigned STATE_W       = 3;
    localparam int unsigned DEF_WORD_W    = 8;
    localparam int unsigned DEF_CHAIN_LEN = 256;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage : config_chain_pkg

// File: rtl/ccff_piso.sv
// ccff_piso: parallel-load, LSB-first shift register feeding the ccff chain head.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture din (has priority over shift)
//   shift      : shift right by one, bit 0 leaves first
//   din        : parallel word
//   lsb_nxt_c  : bit 0 of the register after this edge (combinational look-ahead)
module ccff_piso #(
    parameter int unsigned WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              shift,
    input  logic [WORD_W-1:0] din,
    output logic              lsb_nxt_c
);

    logic [WORD_W-1:0] sreg;
    logic [WORD_W-1:0] sreg_nxt;

    // Next register value: load wins over shift.
    always_comb begin
        sreg_nxt = sreg;
        if (load) begin
            sreg_nxt = din;
        end else if (shift) begin
            sreg_nxt = sreg >> 1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg <= '0;
        end else begin
            sreg <= sreg_nxt;
        end
    end

    // Lets the parent register ccff_head in the same cycle the bit becomes current.
    assign lsb_nxt_c = sreg_nxt[0];

endmodule : ccff_piso

// File: rtl/config_chain_loader.sv
// config_chain_loader: word-to-serial loader for the fabric configuration chain.
// Accepts words on a valid/ready handshake and shifts them LSB-first into
// ccff_head, pulsing shift_en exactly CHAIN_LEN times per load.
// Optional feature macro: CONFIG_PARITY_EN (even-parity check word after the
// last chain bit; parity_err tied 0 when undefined).
//   prog_clk, prog_reset_n : clock, asynchronous active-low reset
//   start                  : begin a load (honoured in IDLE/DONE only)
//   word_in, word_valid    : bitstream word and its valid
//   word_ready             : loader accepts a word this cycle
//   ccff_head, shift_en    : serial data and shift enable into the chain
//   busy, done, parity_err : status
module config_chain_loader
    import config_chain_pkg::*;
#(
    parameter int unsigned WORD_W    = DEF_WORD_W,
    parameter int unsigned CHAIN_LEN = DEF_CHAIN_LEN
) (
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              start,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              ccff_head,
    output logic              shift_en,
    output logic              busy,
    output logic              done,
    output logic              parity_err
);

    localparam int unsigned CNT_W  = $clog2(CHAIN_LEN + 1);
    localparam int unsigned WCNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
    localparam logic [WCNT_W-1:0] LAST_WBIT = WCNT_W'(WORD_W - 1);

`ifdef CONFIG_PARITY_EN
    localparam state_t END_STATE = ST_CHECK;
`else
    localparam state_t END_STATE = ST_DONE;
`endif

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   bit_cnt;
    logic [CNT_W-1:0]   bit_cnt_nxt;
    logic [WCNT_W-1:0]  word_cnt;
    logic [WCNT_W-1:0]  word_cnt_nxt;

    logic word_fire;
    logic start_ok;
    logic piso_load;
    logic piso_shift;
    logic lsb_nxt;

    logic word_ready_nxt;
    logic shift_en_nxt;
    logic ccff_head_nxt;
    logic busy_nxt;
    logic done_nxt;

    // word_ready is only high in LOAD/CHECK, so this is a handshake in those states.
    assign word_fire = word_valid & word_ready;
    assign start_ok  = start & ((state == ST_IDLE) | (state == ST_DONE));

    // State register.
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; the bit count is checked before the word count so a
    // chain ending mid-word drops the remaining word bits.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                if (word_fire) state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (bit_cnt == LAST_BIT) begin
                    state_nxt = END_STATE;
                end else if (word_cnt == LAST_WBIT) begin
                    state_nxt = ST_LOAD;
                end
            end
`ifdef CONFIG_PARITY_EN
            ST_CHECK: begin
                if (word_fire) state_nxt = ST_DONE;
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output/counter next values, decoded from the next state so every
    // output flop lines up with the state it describes.
    always_comb begin
        piso_load      = (state == ST_LOAD) & word_fire;
        piso_shift     = (state == ST_SHIFT);
        word_ready_nxt = (state_nxt == ST_LOAD) | (state_nxt == ST_CHECK);
        shift_en_nxt   = (state_nxt == ST_SHIFT);
        ccff_head_nxt  = shift_en_nxt & lsb_nxt;
        busy_nxt       = (state_nxt == ST_LOAD) | (state_nxt == ST_SHIFT) |
                         (state_nxt == ST_CHECK);
        done_nxt       = (state_nxt == ST_DONE);
        bit_cnt_nxt    = bit_cnt;
        word_cnt_nxt   = word_cnt;
        if (start_ok) begin
            bit_cnt_nxt = '0;
        end
        if (piso_load) begin
            word_cnt_nxt = '0;
        end
        if (piso_shift) begin
            bit_cnt_nxt  = bit_cnt + CNT_W'(1);
            word_cnt_nxt = word_cnt + WCNT_W'(1);
        end
    end

    // Output and counter registers.
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            word_ready <= 1'b0;
            shift_en   <= 1'b0;
            ccff_head  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            bit_cnt    <= '0;
            word_cnt   <= '0;
        end else begin
            word_ready <= word_ready_nxt;
            shift_en   <= shift_en_nxt;
            ccff_head  <= ccff_head_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            bit_cnt    <= bit_cnt_nxt;
            word_cnt   <= word_cnt_nxt;
        end
    end

    ccff_piso #(
        .WORD_W (WORD_W)
    ) u_piso (
        .clk       (prog_clk),
        .rst_n     (prog_reset_n),
        .load      (piso_load),
        .shift     (piso_shift),
        .din       (word_in),
        .lsb_nxt_c (lsb_nxt)
    );

`ifdef CONFIG_PARITY_EN
    logic par_acc;

    // Running XOR of every bit presented to the chain, compared against
    // bit 0 of the check word.
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            par_acc    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (start_ok) begin
                par_acc    <= 1'b0;
                parity_err <= 1'b0;
            end else begin
                if (state == ST_SHIFT) begin
                    par_acc <= par_acc ^ ccff_head;
                end
                if ((state == ST_CHECK) && word_fire) begin
                    parity_err <= par_acc ^ word_in[0];
                end
            end
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule : config_chain_loader
